// File: rtl/move_ctrl_seq.sv
// Moore control sequencer for the bus-based CPU datapath: fetch (T0..T2) with a
// memory-ready wait in T1, then a register-move execute step (T3) for mfhi/mflo.
module move_ctrl_seq #(
    parameter int                  OPCODE_W = 5,
    parameter logic [OPCODE_W-1:0] OP_MFHI  = 5'b11000,
    parameter logic [OPCODE_W-1:0] OP_MFLO  = 5'b11001,
    parameter int                  CNT_W    = 16,
    parameter int                  WAIT_MAX = 15
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic [OPCODE_W-1:0] ir_op,
    input  logic                mem_ready,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                Zlowin,
    output logic                ZLOout,
    output logic                PCin,
    output logic                MDRin,
    output logic                read,
    output logic                MDRout,
    output logic                IRin,
    output logic                Gra,
    output logic                Rin,
    output logic                HIout,
    output logic                LOout,
    output logic                busy,
    output logic                instr_done,
    output logic                illegal_op,
    output logic                bus_err,
    output logic [CNT_W-1:0]    instr_count
);

    localparam int              WAIT_W    = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_T0    = 3'd1;
    localparam logic [2:0] S_T1    = 3'd2;
    localparam logic [2:0] S_T2    = 3'd3;
    localparam logic [2:0] S_T3    = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    logic [2:0]        state;
    logic [2:0]        next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              enter_t1;
    logic              in_t3;
    logic              is_mfhi;
    logic              is_mflo;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (run) next_state = S_T0;
            S_T0:    next_state = S_T1;
            S_T1: begin
                if (mem_ready)
                    next_state = S_T2;
                else if (wait_cnt == WAIT_LAST)
                    next_state = S_ERROR;
            end
            S_T2:    next_state = S_T3;
            S_T3:    next_state = run ? S_T0 : S_IDLE;
            S_ERROR: next_state = S_ERROR;
            default: next_state = S_IDLE;
        endcase
    end

    // PC is written only on the first T1 cycle; wait cycles keep just the read going.
    assign enter_t1 = (next_state == S_T1) && (state != S_T1);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            PCout       <= 1'b0;
            MARin       <= 1'b0;
            IncPC       <= 1'b0;
            Zlowin      <= 1'b0;
            ZLOout      <= 1'b0;
            PCin        <= 1'b0;
            MDRin       <= 1'b0;
            read        <= 1'b0;
            MDRout      <= 1'b0;
            IRin        <= 1'b0;
            busy        <= 1'b0;
            bus_err     <= 1'b0;
            instr_count <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= (state == S_T1 && next_state == S_T1) ? wait_cnt + WAIT_W'(1) : '0;
            PCout    <= (next_state == S_T0);
            MARin    <= (next_state == S_T0);
            IncPC    <= (next_state == S_T0);
            Zlowin   <= (next_state == S_T0);
            ZLOout   <= enter_t1;
            PCin     <= enter_t1;
            MDRin    <= (next_state == S_T1);
            read     <= (next_state == S_T1);
            MDRout   <= (next_state == S_T2);
            IRin     <= (next_state == S_T2);
            busy     <= (next_state != S_IDLE) && (next_state != S_ERROR);
            bus_err  <= bus_err || (next_state == S_ERROR);
            if (in_t3 && (is_mfhi || is_mflo))
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    // IR is only loaded at the end of T2, so the execute controls qualify the
    // registered T3 state with the live opcode; both sources are flop outputs.
    assign in_t3      = (state == S_T3);
    assign is_mfhi    = in_t3 && (ir_op == OP_MFHI);
    assign is_mflo    = in_t3 && (ir_op == OP_MFLO);
    assign Gra        = is_mfhi || is_mflo;
    assign Rin        = is_mfhi || is_mflo;
    assign HIout      = is_mfhi;
    assign LOout      = is_mflo;
    assign instr_done = is_mfhi || is_mflo;
    assign illegal_op = in_t3 && !is_mfhi && !is_mflo;

endmodule

// File: tb/tb_move_ctrl_seq.sv
// Bench for move_ctrl_seq: per-cycle expected control words built from an
// instruction-level timeline (T0, T1 + waits, T2, T3), directed and random.
module tb_move_ctrl_seq;

    localparam logic [4:0] OP_MFHI  = 5'b11000;
    localparam logic [4:0] OP_MFLO  = 5'b11001;
    localparam int         WAIT_MAX = 15;

    // {T0:PCout MARin IncPC Zlowin}{T1:ZLOout PCin MDRin read}{T2:MDRout IRin}
    // {T3:Gra Rin HIout LOout}{busy instr_done illegal_op bus_err}
    localparam logic [17:0] V_IDLE = 18'b0000_0000_00_0000_0000;
    localparam logic [17:0] V_T0   = 18'b1111_0000_00_0000_1000;
    localparam logic [17:0] V_T1F  = 18'b0000_1111_00_0000_1000;
    localparam logic [17:0] V_T1W  = 18'b0000_0011_00_0000_1000;
    localparam logic [17:0] V_T2   = 18'b0000_0000_11_0000_1000;
    localparam logic [17:0] V_T3HI = 18'b0000_0000_00_1110_1100;
    localparam logic [17:0] V_T3LO = 18'b0000_0000_00_1101_1100;
    localparam logic [17:0] V_T3IL = 18'b0000_0000_00_0000_1010;
    localparam logic [17:0] V_ERR  = 18'b0000_0000_00_0000_0001;

    logic        clock = 1'b0;
    logic        clear;
    logic        run;
    logic [4:0]  ir_op;
    logic        mem_ready;
    logic        PCout, MARin, IncPC, Zlowin, ZLOout, PCin, MDRin, read;
    logic        MDRout, IRin, Gra, Rin, HIout, LOout;
    logic        busy, instr_done, illegal_op, bus_err;
    logic [15:0] instr_count;

    move_ctrl_seq dut (
        .clock(clock), .clear(clear), .run(run), .ir_op(ir_op), .mem_ready(mem_ready),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zlowin(Zlowin),
        .ZLOout(ZLOout), .PCin(PCin), .MDRin(MDRin), .read(read),
        .MDRout(MDRout), .IRin(IRin),
        .Gra(Gra), .Rin(Rin), .HIout(HIout), .LOout(LOout),
        .busy(busy), .instr_done(instr_done), .illegal_op(illegal_op),
        .bus_err(bus_err), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        run;
        logic        mr;
        logic [4:0]  op;
        logic [17:0] exp;
        logic [15:0] cnt;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] m_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic logic [17:0] obs();
        return {PCout, MARin, IncPC, Zlowin, ZLOout, PCin, MDRin, read, MDRout, IRin,
                Gra, Rin, HIout, LOout, busy, instr_done, illegal_op, bus_err};
    endfunction

    task automatic check_vec(input string name, input int idx, input logic [17:0] act,
                             input logic [17:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] controls actual=%b required=%b", name, idx, act, exp);
        end
    endtask

    task automatic check_cnt(input string name, input int idx, input logic [15:0] exp);
        n_tests++;
        if (instr_count !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] instr_count actual=%0d required=%0d", name, idx, instr_count, exp);
        end
    endtask

    task automatic check_inv(input string name, input int idx);
        logic [4:0] drv;
        drv = {PCout, ZLOout, MDRout, HIout, LOout};
        n_tests++;
        if (!$onehot0(drv)) begin
            n_fail++;
            $display("FAIL %s[%0d] bus_drivers actual=%b required=onehot0", name, idx, drv);
        end
    endtask

    function automatic void push(input logic r, input logic mr, input logic [4:0] op,
                                 input logic [17:0] exp);
        vec_t v;
        v.run = r; v.mr = mr; v.op = op; v.exp = exp; v.cnt = m_cnt;
        tbl.push_back(v);
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [4:0] rop();
        return 5'($urandom_range(0, 31));
    endfunction

    // One instruction: w cycles of mem_ready=0 in T1 before ready (w <= WAIT_MAX).
    function automatic void add_instr(input int w, input logic [4:0] op, input logic run_exit);
        logic legal;
        legal = (op == OP_MFHI) || (op == OP_MFLO);
        push(rb(), rb(), rop(), V_T0);
        for (int i = 0; i <= w; i++)
            push(rb(), (i == w), rop(), (i == 0) ? V_T1F : V_T1W);
        push(rb(), rb(), rop(), V_T2);
        push(run_exit, rb(), op,
             (op == OP_MFHI) ? V_T3HI : (op == OP_MFLO) ? V_T3LO : V_T3IL);
        if (legal) m_cnt = m_cnt + 16'd1;
    endfunction

    function automatic void add_idle(input logic r);
        push(r, rb(), rop(), V_IDLE);
    endfunction

    task automatic apply(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            run       = tbl[i].run;
            mem_ready = tbl[i].mr;
            ir_op     = tbl[i].op;
            #1;
            check_vec(name, i, obs(), tbl[i].exp);
            check_cnt(name, i, tbl[i].cnt);
            check_inv(name, i);
        end
        tbl.delete();
    endtask

    task automatic do_clear(input string name, input logic run_after);
        @(negedge clock);
        clear = 1'b1;
        run   = 1'b0;
        #1;
        check_vec(name, 0, obs(), V_IDLE);
        check_cnt(name, 0, 16'd0);
        @(negedge clock);
        clear = 1'b0;
        run   = run_after;
        m_cnt = 16'd0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1'b1; run = 1'b0; mem_ready = 1'b0; ir_op = 5'd0; m_cnt = 16'd0;
        #2;
        check_vec("reset", 0, obs(), V_IDLE);
        check_cnt("reset", 0, 16'd0);
        do_clear("reset_rel", 1'b0);

        // Directed timeline
        add_idle(1'b0); add_idle(1'b0); add_idle(1'b1);
        add_instr(0, OP_MFLO, 1'b1);
        for (int k = 0; k < 3; k++) add_instr(0, OP_MFHI, 1'b1);
        add_instr(3, OP_MFHI, 1'b1);
        add_instr(WAIT_MAX, OP_MFLO, 1'b1);
        add_instr(0, 5'b00000, 1'b0);
        add_idle(1'b0);
        apply("directed");
        check_cnt("directed_total", 0, 16'd6);

        // Asynchronous clear in the middle of a T1 wait
        add_idle(1'b1);
        push(1'b0, 1'b0, 5'd0, V_T0);
        push(1'b0, 1'b0, 5'd0, V_T1F);
        push(1'b0, 1'b0, 5'd0, V_T1W);
        apply("pre_clear");
        #2;
        clear = 1'b1;
        #1;
        check_vec("async_clear", 0, obs(), V_IDLE);
        check_cnt("async_clear", 0, 16'd0);
        @(negedge clock);
        clear = 1'b0;
        run   = 1'b1;
        m_cnt = 16'd0;
        add_instr(0, OP_MFHI, 1'b0);
        add_idle(1'b0);
        apply("post_clear");

        // T1 timeout: 16 cycles of mem_ready=0, then sticky ERROR with run held
        add_idle(1'b1);
        push(1'b1, 1'b0, rop(), V_T0);
        push(1'b1, 1'b0, rop(), V_T1F);
        for (int k = 0; k < WAIT_MAX; k++) push(1'b1, 1'b0, rop(), V_T1W);
        for (int k = 0; k < 4; k++) push(1'b1, rb(), rop(), V_ERR);
        apply("timeout");
        do_clear("err_clear", 1'b0);
        add_idle(1'b0);
        apply("err_cleared");

        // Random instruction stream
        add_idle(1'b1);
        for (int n = 0; n < 300; n++) begin
            int         sel;
            int         w;
            logic [4:0] op;
            logic       rx;
            sel = $urandom_range(0, 3);
            op  = (sel == 0) ? OP_MFHI : (sel == 1) ? OP_MFLO : rop();
            w   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, WAIT_MAX) : $urandom_range(0, 2);
            rx  = ($urandom_range(0, 4) != 0);
            add_instr(w, op, rx);
            if (!rx) begin
                int k;
                k = $urandom_range(0, 2);
                for (int j = 0; j < k; j++) add_idle(1'b0);
                add_idle(1'b1);
            end
        end
        apply("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
